// File: rtl/ov7670_frame_capture_if.sv
// ----------------------------------------------------------------------------
// ov7670_frame_capture_if
//   Bundles the OV7670 DVP bus and the camera-FIFO write port that the
//   capture stage sits between.
//
//   Signals:
//     cam_vsync    camera VSYNC, high = vertical blank, low = active frame
//     href         camera line-valid
//     p_data[7:0]  camera data byte
//     queue_full   FIFO Full flag
//     queue_data   FIFO Data word, bit 16 = frame-start marker flag
//     queue_wr_en  FIFO WrEn strobe
//
//   Modports:
//     master  the capture block (samples camera, drives the FIFO write side)
//     slave   the environment (drives camera and FIFO status, sees writes)
// ----------------------------------------------------------------------------
interface ov7670_frame_capture_if;
    logic        cam_vsync;
    logic        href;
    logic [7:0]  p_data;
    logic        queue_full;
    logic [16:0] queue_data;
    logic        queue_wr_en;

    modport master (
        input  cam_vsync, href, p_data, queue_full,
        output queue_data, queue_wr_en
    );

    modport slave (
        output cam_vsync, href, p_data, queue_full,
        input  queue_data, queue_wr_en
    );
endinterface

// File: rtl/ov7670_frame_capture.sv
// ----------------------------------------------------------------------------
// ov7670_frame_capture
//   Samples the OV7670 DVP bus on the pixel clock, packs byte pairs into
//   RGB565 pixels and pushes 17-bit words into the camera FIFO: one marker
//   (17'h10000) at frame start, then {1'b0, pixel} per pixel. A word that is
//   due while the FIFO is full drops the rest of that frame.
//
//   Ports:
//     clk          camera pixel clock
//     reset_p      synchronous, active-high reset
//     calib_done   memory calibration complete (level); low parks the FSM
//     bus          ov7670_frame_capture_if.master (camera in, FIFO write out)
//     frame_done   one-cycle pulse at the end of a completed frame
//     overflow     sticky: a word was due while the FIFO was full
//     size_error   sticky frame-geometry error (0 unless size check built in)
//     frame_count  completed frames, wraps at 16'hFFFF
//
//   Optional feature: define CAPTURE_SIZE_CHECK_EN to build per-line pixel
//   and per-frame line counters that check against FRAME_WIDTH/FRAME_HEIGHT.
// ----------------------------------------------------------------------------
module ov7670_frame_capture #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          reset_p,
    input  logic                          calib_done,
    ov7670_frame_capture_if.master        bus,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          size_error,
    output logic [15:0]                   frame_count
);

    typedef enum logic [2:0] {
        WAIT_CALIBRATION,
        WAIT_VSYNC_HIGH,
        WAIT_FRAME_START,
        ROW_CAPTURE,
        DROP_FRAME
    } state_t;

    if (FRAME_WIDTH < 1 || FRAME_HEIGHT < 1) begin : g_bad_geometry
        $error("ov7670_frame_capture: FRAME_WIDTH and FRAME_HEIGHT must be positive");
    end

    // Stage 1: raw camera inputs registered once.
    logic       r_cam_vsync;
    logic       r_href;
    logic [7:0] r_p_data;
    // Stage 2: VSYNC level/edges and the byte stream, aligned so that every
    // FSM decision (marker, pixel, frame end) lands two edges after sampling.
    logic       r_vsync_d;
    logic       r_vsync_rise;
    logic       r_vsync_fall;
    logic       r_href_d;
    logic [7:0] r_p_data_d;

    state_t     r_state;
    logic       r_pixel_half;   // 1 = high byte already held in r_pixel_hi
    logic [7:0] r_pixel_hi;

`ifdef CAPTURE_SIZE_CHECK_EN
    localparam int PIX_CNT_W  = $clog2(FRAME_WIDTH + 1);
    localparam int LINE_CNT_W = $clog2(FRAME_HEIGHT + 1);
    logic                  r_href_prev;
    logic [PIX_CNT_W-1:0]  r_pix_cnt;
    logic [LINE_CNT_W-1:0] r_line_cnt;
    logic                  r_size_error;
    assign size_error = r_size_error;
`else
    assign size_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_p) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every stage reads the value from before this edge.
            r_cam_vsync  <= 1'b0;
            r_href       <= 1'b0;
            r_p_data     <= '0;
            r_vsync_d    <= 1'b0;
            r_vsync_rise <= 1'b0;
            r_vsync_fall <= 1'b0;
            r_href_d     <= 1'b0;
            r_p_data_d   <= '0;
`ifdef CAPTURE_SIZE_CHECK_EN
            r_href_prev  <= 1'b0;
`endif
        end else begin
            r_cam_vsync  <= bus.cam_vsync;
            r_href       <= bus.href;
            r_p_data     <= bus.p_data;
            r_vsync_d    <= r_cam_vsync;
            r_vsync_rise <= r_cam_vsync & ~r_vsync_d;
            r_vsync_fall <= ~r_cam_vsync & r_vsync_d;
            r_href_d     <= r_href;
            r_p_data_d   <= r_p_data;
`ifdef CAPTURE_SIZE_CHECK_EN
            r_href_prev  <= r_href_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state         <= WAIT_CALIBRATION;
            r_pixel_half    <= 1'b0;
            r_pixel_hi      <= '0;
            bus.queue_data  <= '0;
            bus.queue_wr_en <= 1'b0;
            frame_done      <= 1'b0;
            overflow        <= 1'b0;
            frame_count     <= '0;
`ifdef CAPTURE_SIZE_CHECK_EN
            r_pix_cnt       <= '0;
            r_line_cnt      <= '0;
            r_size_error    <= 1'b0;
`endif
        end else begin
            // Strobes default low so each write/pulse lasts one cycle.
            bus.queue_wr_en <= 1'b0;
            frame_done      <= 1'b0;

            if (!calib_done) begin
                // Losing calibration abandons the frame; nothing is written.
                r_state      <= WAIT_CALIBRATION;
                r_pixel_half <= 1'b0;
            end else begin
                unique case (r_state)
                    WAIT_CALIBRATION: r_state <= WAIT_VSYNC_HIGH;

                    // Only a blank period seen first guarantees we never
                    // start capturing in the middle of a frame.
                    WAIT_VSYNC_HIGH: if (r_vsync_d) r_state <= WAIT_FRAME_START;

                    WAIT_FRAME_START: begin
                        r_pixel_half <= 1'b0;
                        if (r_vsync_fall) begin
                            if (bus.queue_full) begin
                                overflow <= 1'b1;
                                r_state  <= DROP_FRAME;
                            end else begin
                                bus.queue_wr_en <= 1'b1;
                                bus.queue_data  <= 17'h10000;
                                r_state         <= ROW_CAPTURE;
`ifdef CAPTURE_SIZE_CHECK_EN
                                r_pix_cnt       <= '0;
                                r_line_cnt      <= '0;
`endif
                            end
                        end
                    end

                    ROW_CAPTURE: begin
                        if (r_vsync_rise) begin
                            // Frame end wins over a pixel completing this cycle.
                            frame_done   <= 1'b1;
                            frame_count  <= frame_count + 16'd1;
                            r_pixel_half <= 1'b0;
                            r_state      <= WAIT_FRAME_START;
`ifdef CAPTURE_SIZE_CHECK_EN
                            if (r_line_cnt != LINE_CNT_W'(FRAME_HEIGHT)) r_size_error <= 1'b1;
`endif
                        end else if (r_href_d) begin
                            r_pixel_half <= ~r_pixel_half;
                            if (!r_pixel_half) begin
                                r_pixel_hi <= r_p_data_d;
                            end else if (bus.queue_full) begin
                                overflow     <= 1'b1;
                                r_pixel_half <= 1'b0;
                                r_state      <= DROP_FRAME;
                            end else begin
                                bus.queue_wr_en <= 1'b1;
                                bus.queue_data  <= {1'b0, r_pixel_hi, r_p_data_d};
`ifdef CAPTURE_SIZE_CHECK_EN
                                r_pix_cnt       <= r_pix_cnt + PIX_CNT_W'(1);
`endif
                            end
                        end else begin
                            // Line gap: an unpaired trailing byte is discarded.
                            r_pixel_half <= 1'b0;
`ifdef CAPTURE_SIZE_CHECK_EN
                            if (r_href_prev) begin
                                if (r_pix_cnt != PIX_CNT_W'(FRAME_WIDTH)) r_size_error <= 1'b1;
                                r_pix_cnt  <= '0;
                                r_line_cnt <= r_line_cnt + LINE_CNT_W'(1);
                            end
`endif
                        end
                    end

                    DROP_FRAME: begin
                        r_pixel_half <= 1'b0;
                        if (r_vsync_rise) r_state <= WAIT_FRAME_START;
                    end

                    default: r_state <= WAIT_CALIBRATION;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// ----------------------------------------------------------------------------
// tb_ov7670_frame_capture
//   Directed bench for ov7670_frame_capture with FRAME_WIDTH = FRAME_HEIGHT = 4.
//   Inputs change on the falling clock edge; a monitor records FIFO writes
//   and frame_done pulses 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_ov7670_frame_capture;

    localparam int FW = 4;
    localparam int FH = 4;

`ifdef CAPTURE_SIZE_CHECK_EN
    localparam logic SIZE_CHK = 1'b1;
`else
    localparam logic SIZE_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_p;
    logic        calib_done;
    logic        frame_done;
    logic        overflow;
    logic        size_error;
    logic [15:0] frame_count;

    ov7670_frame_capture_if bus ();

    ov7670_frame_capture #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH)
    ) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .calib_done (calib_done),
        .bus        (bus),
        .frame_done (frame_done),
        .overflow   (overflow),
        .size_error (size_error),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_done = 0;
    int          n_b2b = 0;
    int          n_wr_full = 0;
    int          bidx = 0;
    logic        prev_wr = 1'b0;
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] byte_of(input int k);
        return 8'(161 + 17 * k);   // A1, B2, C3, D4, E5, F6, 07, 18, ...
    endfunction

    // Writes seen by the FIFO, plus rule violations on the write strobe.
    always @(posedge clk) begin
        #1;
        if (bus.queue_wr_en === 1'b1) begin
            got_q.push_back(bus.queue_data);
            if (prev_wr === 1'b1) n_b2b++;
            if (bus.queue_full === 1'b1) n_wr_full++;
        end
        prev_wr = bus.queue_wr_en;
        if (frame_done === 1'b1) n_done++;
    end

    task automatic send_line(input int n_bytes, input bit capture, input bit rise_last);
        logic [7:0] hi;
        hi = 8'h00;
        for (int b = 0; b < n_bytes; b++) begin
            bus.href   = 1'b1;
            bus.p_data = byte_of(bidx);
            bidx++;
            if (rise_last && b == n_bytes - 1) bus.cam_vsync = 1'b1;
            if (b % 2 == 0) hi = bus.p_data;
            else if (capture && !(rise_last && b == n_bytes - 1))
                exp_q.push_back({1'b0, hi, bus.p_data});
            tick(1);
        end
        bus.href   = 1'b0;
        bus.p_data = 8'h00;
        tick(5);
    endtask

    task automatic run_frame(input int n_lines, input int first_bytes, input int full_line,
                             input bit rise_last, input bit capture);
        bidx = 0;
        bus.cam_vsync = 1'b0;
        if (capture) exp_q.push_back(17'h10000);
        tick(6);
        for (int l = 0; l < n_lines; l++) begin
            if (l == full_line) bus.queue_full = 1'b1;
            send_line((l == 0) ? first_bytes : 2 * FW,
                      capture && (full_line < 0 || l < full_line),
                      rise_last && (l == n_lines - 1));
            bus.queue_full = 1'b0;
        end
        bus.cam_vsync = 1'b1;
        tick(8);
    endtask

    task automatic compare_words(input string tag, input int exp_done);
        check({tag, "_n_words"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_frame_done"}, 32'(n_done), 32'(exp_done));
        got_q.delete();
        exp_q.delete();
        n_done = 0;
    endtask

    function automatic logic [16:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 17'h1FFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_p        = 1'b1;
        calib_done     = 1'b0;
        bus.cam_vsync  = 1'b1;
        bus.href       = 1'b0;
        bus.p_data     = 8'h00;
        bus.queue_full = 1'b0;
        tick(3);
        check("rst_wr_en",       32'(bus.queue_wr_en), 32'd0);
        check("rst_data",        32'(bus.queue_data),  32'd0);
        check("rst_frame_done",  32'(frame_done),      32'd0);
        check("rst_overflow",    32'(overflow),        32'd0);
        check("rst_size_error",  32'(size_error),      32'd0);
        check("rst_frame_count", 32'(frame_count),     32'd0);
        reset_p = 1'b0;

        // No calibration: VSYNC and lines toggle, nothing may be written.
        run_frame(2, 2 * FW, -1, 1'b0, 1'b0);
        bus.cam_vsync = 1'b0; tick(4);
        bus.cam_vsync = 1'b1; tick(4);
        compare_words("no_calib", 0);

        // Calibration completes mid-frame: wait for a full blank->active sequence.
        bus.cam_vsync = 1'b0; tick(4);
        calib_done = 1'b1; tick(2);
        bidx = 0;
        send_line(2 * FW, 1'b0, 1'b0);
        send_line(2 * FW, 1'b0, 1'b0);
        check("midframe_no_words", 32'(got_q.size()), 32'd0);
        bus.cam_vsync = 1'b1; tick(8);
        run_frame(FH, 2 * FW, -1, 1'b0, 1'b1);
        check("f1_marker",      32'(got_at(0)), 32'h10000);
        check("f1_first_pixel", 32'(got_at(1)), 32'h0A1B2);
        check("f1_second_pixel",32'(got_at(2)), 32'h0C3D4);
        compare_words("frame1", 1);
        check("f1_frame_count", 32'(frame_count), 32'd1);
        check("f1_size_error",  32'(size_error),  32'd0);
        check("f1_overflow",    32'(overflow),    32'd0);

        // First line carries 7 bytes: 3 pixels, trailing byte dropped.
        run_frame(FH, 7, -1, 1'b0, 1'b1);
        check("odd_n_words",    32'(got_q.size()), 32'd16);
        check("odd_pixel3",     32'(got_at(3)), 32'h0E5F6);
        check("odd_next_line",  32'(got_at(4)), 32'h01829);
        compare_words("odd", 1);
        check("odd_frame_count",32'(frame_count), 32'd2);
        check("odd_size_error", 32'(size_error),  32'(SIZE_CHK));

        // FIFO full on the 5th pixel: rest of the frame dropped.
        run_frame(FH, 2 * FW, 1, 1'b0, 1'b1);
        check("drop_n_words",    32'(got_q.size()), 32'd5);
        compare_words("drop", 0);
        check("drop_overflow",   32'(overflow),    32'd1);
        check("drop_frame_count",32'(frame_count), 32'd2);

        // Next frame recovers with a marker and full capture.
        run_frame(FH, 2 * FW, -1, 1'b0, 1'b1);
        check("rec_marker",      32'(got_at(0)), 32'h10000);
        compare_words("recover", 1);
        check("rec_frame_count", 32'(frame_count), 32'd3);
        check("rec_overflow",    32'(overflow),    32'd1);

        // VSYNC rises with the final second byte: frame end wins.
        run_frame(FH, 2 * FW, -1, 1'b1, 1'b1);
        check("race_n_words",    32'(got_q.size()), 32'd16);
        compare_words("race", 1);
        check("race_frame_count",32'(frame_count), 32'd4);

        // Reset pulse in the middle of a line.
        bidx = 0;
        bus.cam_vsync = 1'b0; tick(6);
        send_line(2 * FW, 1'b0, 1'b0);
        bus.href = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.p_data = byte_of(b);
            tick(1);
        end
        reset_p = 1'b1;
        bus.p_data = byte_of(3);
        tick(1);
        check("mrst_wr_en",       32'(bus.queue_wr_en), 32'd0);
        check("mrst_data",        32'(bus.queue_data),  32'd0);
        check("mrst_frame_done",  32'(frame_done),      32'd0);
        check("mrst_overflow",    32'(overflow),        32'd0);
        check("mrst_size_error",  32'(size_error),      32'd0);
        check("mrst_frame_count", 32'(frame_count),     32'd0);
        reset_p = 1'b0;
        got_q.delete();
        exp_q.delete();
        n_done = 0;
        for (int b = 4; b < 2 * FW; b++) begin
            bus.p_data = byte_of(b);
            tick(1);
        end
        bus.href = 1'b0; tick(5);
        send_line(2 * FW, 1'b0, 1'b0);
        bus.cam_vsync = 1'b1; tick(8);
        compare_words("after_reset", 0);
        run_frame(FH, 2 * FW, -1, 1'b0, 1'b1);
        compare_words("post_reset", 1);
        check("post_frame_count", 32'(frame_count), 32'd1);

        check("no_back_to_back_writes", 32'(n_b2b),     32'd0);
        check("no_write_while_full",    32'(n_wr_full), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ov7670_frame_capture.md
# ov7670_frame_capture

Camera-side capture stage that sits directly upstream of the camera input FIFO (`FIFO_cam`, write side). It samples the OV7670 DVP bus (`cam_vsync`, `href`, `p_data`) on the camera pixel clock and packs byte pairs into RGB565 pixels. It pushes 17-bit queue words, a frame-start marker followed by pixel words, into the FIFO. It also handles back-pressure by dropping the rest of the frame, and reports frame and error status.

## Interface
Parameters:
- `FRAME_WIDTH`, 640, expected pixels per line (size check only)
- `FRAME_HEIGHT`, 480, expected lines per frame (size check only)

Ports:
- Clock and reset: one clock (`clk`); reset (`reset_p`) is synchronous and active-high.
- `clk`  in  1  camera pixel clock (`PixelClk`)
- `reset_p`  in  1  synchronous, active-high reset
- `calib_done`  in  1  PSRAM init/calibration complete (level)
- `cam_vsync`  in  1  camera VSYNC; high = vertical blank, low = active frame
- `href`  in  1  camera line-valid
- `p_data`  in  8  camera data byte
- `queue_full`  in  1  FIFO `Full`
- `queue_data`  out  17  FIFO `Data`; bit 16 = marker flag
- `queue_wr_en`  out  1  FIFO `WrEn`
- `frame_done`  out  1  one-cycle pulse at end of a completed (not dropped) frame
- `overflow`  out  1  sticky: a word was due while `queue_full` was high
- `size_error`  out  1  sticky frame-geometry error (see Configuration)
- `frame_count`  out  16  completed frames, wraps at 16'hFFFF→0

## Operation
- Input stage: `cam_vsync`, `href`, `p_data` are registered once (`_r`). All FSM decisions use registered values. VSYNC edges are detected from `cam_vsync_r` against its previous value.
- States:
  - WAIT_CALIBRATION: stays here until `calib_done`=1, then goes to WAIT_VSYNC_HIGH.
  - WAIT_VSYNC_HIGH: waits for `cam_vsync_r`=1, then goes to WAIT_FRAME_START. This guarantees capture never starts mid-frame.
  - WAIT_FRAME_START: on a VSYNC falling edge it writes marker 17'h10000 and goes to ROW_CAPTURE. If `queue_full`=1 at that cycle, it sets `overflow`, skips the marker and goes to DROP_FRAME.
  - ROW_CAPTURE: byte phase `pixel_half` toggles on each cycle with `href_r`=1.
    - First byte goes to `pixel_data[15:8]`.
    - Second byte goes to `[7:0]`, and the block then writes `{1'b0, pixel_data}`.
    - `href_r`=0 clears `pixel_half`, so an odd trailing byte is discarded.
    - A write due while `queue_full`=1 is dropped, sets `overflow`, and the FSM goes to DROP_FRAME.
    - A VSYNC rising edge pulses `frame_done`, increments `frame_count`, and returns to WAIT_FRAME_START.
  - DROP_FRAME: no writes; on a VSYNC rising edge goes to WAIT_FRAME_START. There is no `frame_done` and no count increment.
- `calib_done` falling in any state returns the FSM to WAIT_CALIBRATION. Any write due that cycle is suppressed.
- Simultaneous VSYNC rise and completed pixel in the same cycle: frame end wins and the pixel is not written.
- `overflow` and `size_error` clear only on reset.

## Timing
- Reset values: `queue_data`=0, `queue_wr_en`=0, `frame_done`=0, `overflow`=0, `size_error`=0, `frame_count`=0, FSM in WAIT_CALIBRATION, `pixel_half`=0.
- Reset mid-frame: all outputs return to reset values on the next edge. With `calib_done` high, the block waits for a fresh VSYNC high→low sequence before writing.
- Latency: a second byte sampled at edge k gives `queue_wr_en`=1 with the pixel after edge k+2. The marker follows the VSYNC low sample by 2 edges, the same as pixels.
- `queue_wr_en` is high for exactly one cycle per word. Words are at most one every 2 cycles, except the marker.
- `queue_full` is sampled in the same cycle the write is issued. The write is never asserted while `queue_full`=1.
- `frame_done` asserts 2 edges after the VSYNC rise is sampled.

## Configuration
- `CAPTURE_SIZE_CHECK_EN` defined:
  - A pixel counter (width `$clog2(FRAME_WIDTH+1)`) counts written pixels per line. On each `href_r` falling edge in ROW_CAPTURE, a count ≠ `FRAME_WIDTH` sets `size_error`.
  - A line counter is compared to `FRAME_HEIGHT` at frame end; a mismatch sets `size_error`.
  - Both counters clear at frame start. Dropped frames are not checked.
- Not defined: there are no counters, and `size_error` is tied to 0.

## Test plan
- Reset, `calib_done`=0, VSYNC toggling → no `queue_wr_en` ever. Then `calib_done`=1 mid-frame (VSYNC low) → no writes until VSYNC goes high then low; first word is 17'h10000.
- Frame of 4 lines × 4 pixels, bytes 8'hA1,8'hB2,... → marker plus 16 words 17'h0A1B2...; `frame_done` one pulse; `frame_count`=1.
- Line with 7 `href` bytes → 3 pixel words; last byte discarded; with `CAPTURE_SIZE_CHECK_EN` and `FRAME_WIDTH`=4 → `size_error`=1.
- `queue_full`=1 on the 5th pixel → that word and the rest of the frame not written; `overflow`=1; no `frame_done`; next frame starts with a marker and captures normally.
- VSYNC rise in the same cycle as a completed second byte → pixel not written; `frame_done` pulses.
- `reset_p` pulse mid-line → all outputs 0 next cycle; `frame_count`=0; no pixel words until the next full VSYNC sequence.
